// File: rtl/snoopy_bus_arbiter.sv
// ---------------------------------------------------------------------------
// snoopy_bus_arbiter
//
// Shares one snoopy bus between NUM_CACHES write-through-invalidate cache
// controllers. A round-robin pointer picks the next requester. The winner's
// command is latched and broadcast for one cycle. Snoop acks from every other
// cache are then collected. The winner keeps the bus until it pulses done.
//
// Optional feature: define SNOOPY_BUS_ARBITER_WATCHDOG_EN to bound the time
// spent in SNOOP+HOLD to MAX_HOLD_CYCLES. When the limit is hit, the tenure is
// forcibly ended and timeout_error pulses for one cycle. Without the macro,
// timeout_error is tied low and a tenure can last forever.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   request        in   [NUM_CACHES]                per-cache bus request (level)
//   command_in     in   [NUM_CACHES*COMMAND_WIDTH]  per-cache command, slice i = cache i
//   snoop_ack      in   [NUM_CACHES]                per-cache snoop completion
//   done           in   [NUM_CACHES]                per-cache end-of-tenure pulse
//   grant          out  [NUM_CACHES]                one-hot grant, zero when idle
//   command_out    out  [COMMAND_WIDTH]             latched command of the granted cache
//   command_valid  out  one-cycle broadcast strobe
//   bus_busy       out  high whenever a tenure is in progress
//   timeout_error  out  one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module snoopy_bus_arbiter #(
    parameter int NUM_CACHES      = 4,
    parameter int COMMAND_WIDTH   = 2,
    parameter int MAX_HOLD_CYCLES = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_CACHES-1:0]               request,
    input  logic [NUM_CACHES*COMMAND_WIDTH-1:0] command_in,
    input  logic [NUM_CACHES-1:0]               snoop_ack,
    input  logic [NUM_CACHES-1:0]               done,
    output logic [NUM_CACHES-1:0]               grant,
    output logic [COMMAND_WIDTH-1:0]            command_out,
    output logic                                command_valid,
    output logic                                bus_busy,
    output logic                                timeout_error
);

    localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BROADCAST,
        SNOOP,
        HOLD
    } state_t;

    state_t                    state, state_next;
    logic [NUM_CACHES-1:0]     grant_next;
    logic [COMMAND_WIDTH-1:0]  command_next;
    logic [NUM_CACHES-1:0]     collector, collector_next, collected;
    logic [IDX_W-1:0]          rr_ptr, rr_next;
    logic [IDX_W-1:0]          winner, winner_next;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_found;
    logic                      release_now;
    logic [COMMAND_WIDTH-1:0]  command_slices [NUM_CACHES];

    for (genvar i = 0; i < NUM_CACHES; i++) begin : g_slices
        assign command_slices[i] = command_in[i*COMMAND_WIDTH +: COMMAND_WIDTH];
    end

`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_count, hold_count_next;
    logic             timeout_q, timeout_next;
`else
    logic [31:0] hold_limit_unused;
    assign hold_limit_unused = MAX_HOLD_CYCLES;
`endif

    // Round-robin search: scan cyclically starting just after the pointer,
    // so the previous winner has the lowest priority.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_CACHES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CACHES;
            if (!pick_found && request[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            command_out <= '0;
            collector   <= '0;
            rr_ptr      <= IDX_W'(NUM_CACHES - 1);
            winner      <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            command_out <= command_next;
            collector   <= collector_next;
            rr_ptr      <= rr_next;
            winner      <= winner_next;
        end
    end

`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_count <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_count <= hold_count_next;
            timeout_q  <= timeout_next;
        end
    end
`endif

    // The winner's own ack is masked out, so the collector is complete when it
    // equals ~grant. With a single cache, ~grant is zero and SNOOP lasts one cycle.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        command_next   = command_out;
        collector_next = collector;
        rr_next        = rr_ptr;
        winner_next    = winner;
        collected      = collector | (snoop_ack & ~grant);
        release_now    = |(done & grant);
`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
        hold_count_next = hold_count;
        timeout_next    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next     = BROADCAST;
                    grant_next     = NUM_CACHES'(1) << pick_idx;
                    command_next   = command_slices[pick_idx];
                    winner_next    = pick_idx;
                    collector_next = '0;
`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
                    hold_count_next = '0;
`endif
                end
            end
            BROADCAST: begin
                collector_next = snoop_ack & ~grant;
                state_next     = SNOOP;
            end
            SNOOP: begin
                collector_next = collected;
                if (collected == ~grant) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (release_now) begin
                    state_next     = IDLE;
                    grant_next     = '0;
                    command_next   = '0;
                    collector_next = '0;
                    rr_next        = winner;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
        // A done arriving in the limit cycle wins over the watchdog.
        if (state == SNOOP || state == HOLD) begin
            if (!(state == HOLD && release_now) && hold_count == LAST_COUNT) begin
                state_next     = IDLE;
                grant_next     = '0;
                command_next   = '0;
                collector_next = '0;
                rr_next        = winner;
                timeout_next   = 1'b1;
            end else begin
                hold_count_next = hold_count + 1'b1;
            end
        end
`endif
    end

    assign command_valid = (state == BROADCAST);
    assign bus_busy      = (state != IDLE);
`ifdef SNOOPY_BUS_ARBITER_WATCHDOG_EN
    assign timeout_error = timeout_q;
`else
    assign timeout_error = 1'b0;
`endif

endmodule
